// File: rtl/noc_pkg.sv
// noc_pkg: shared flit format for the local network interface.
package noc_pkg;
  localparam int FLIT_W = 16;
  localparam int COORD_W = 4;
  typedef struct packed {
    logic [7:0]         payload;
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
  } flit_t;
endpackage

// File: rtl/noc_ni_fifo.sv
// noc_ni_fifo: first-word-fall-through sync FIFO with wrap-bit pointers.
module noc_ni_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr, rd;
  assign full  = (wr ^ rd) == {1'b1, {AW{1'b0}}};
  assign empty = wr == rd;
  assign head  = mem[rd[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push && !full) wr <= wr + 1'b1;
      if (pop && !empty) rd <= rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/noc_local_ni.sv
// noc_local_ni: core-side NI packing/injecting single-flit packets under credits and ejecting with credit return.
module noc_local_ni
  import noc_pkg::*;
#(
  parameter int XCOORD    = 1,
  parameter int YCOORD    = 1,
  parameter int INJ_DEPTH = 4,
  parameter int EJ_DEPTH  = 4,
  parameter int CREDITS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inj_valid,
  output logic              inj_ready,
  input  logic [COORD_W-1:0] inj_dest_x,
  input  logic [COORD_W-1:0] inj_dest_y,
  input  logic [7:0]        inj_payload,
  output logic [FLIT_W-1:0] net_out_data,
  output logic              net_out_enable,
  input  logic              net_out_credit,
  input  logic [FLIT_W-1:0] net_in_data,
  input  logic              net_in_enable,
  output logic              net_in_credit,
  output logic              ej_valid,
  input  logic              ej_ready,
  output logic [7:0]        ej_src_payload,
  output logic              err_overflow,
  output logic              err_misroute
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);
  localparam logic [7:0] NODE = {4'(XCOORD), 4'(YCOORD)};
  flit_t       inj_flit, inj_head;
  logic        inj_full, inj_empty, ej_full, ej_empty, send, ej_pop, cr_ovf;
  logic [CW-1:0] credit_cnt;
  assign inj_flit  = '{payload: inj_payload, dx: inj_dest_x, dy: inj_dest_y};
  assign inj_ready = !inj_full;
  assign send      = !inj_empty && credit_cnt != '0;
  assign ej_valid  = !ej_empty;
  assign ej_pop    = ej_valid && ej_ready;
  assign cr_ovf    = net_out_credit && !send && credit_cnt == CMAX;
  noc_ni_fifo #(.WIDTH(FLIT_W), .DEPTH(INJ_DEPTH)) u_inj (
    .clk, .rst, .push(inj_valid && inj_ready), .din(inj_flit), .pop(send),
    .head(inj_head), .full(inj_full), .empty(inj_empty)
  );
  // Only the payload is ever read back by the core, so only it is buffered.
  noc_ni_fifo #(.WIDTH(8), .DEPTH(EJ_DEPTH)) u_ej (
    .clk, .rst, .push(net_in_enable && !ej_full), .din(net_in_data[15:8]), .pop(ej_pop),
    .head(ej_src_payload), .full(ej_full), .empty(ej_empty)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      net_out_enable <= 1'b0;
      net_out_data   <= '0;
      net_in_credit  <= 1'b0;
      credit_cnt     <= CMAX;
      err_overflow   <= 1'b0;
      err_misroute   <= 1'b0;
    end else begin
      net_out_enable <= send;
      if (send) net_out_data <= inj_head;
      net_in_credit <= ej_pop;
      if (send && !net_out_credit) credit_cnt <= credit_cnt - 1'b1;
      else if (!send && net_out_credit && !cr_ovf) credit_cnt <= credit_cnt + 1'b1;
      if (cr_ovf || (net_in_enable && ej_full)) err_overflow <= 1'b1;
      if (net_in_enable && net_in_data[7:0] != NODE) err_misroute <= 1'b1;
    end
endmodule
